fram_port_arbiter: RTL and testbench

- Shares the single-port feature SRAM (FRAM) between three requesters: the host BRAM-controller port, the conv engine's feature-read port, and the conv engine's result-writeback port.
- Sits between the accelerator top and the FRAM macro.
- The host has absolute priority and is never stalled. The two engine ports arbitrate round-robin through a valid/grant handshake.
- Provides a saturating collision counter that reports, through the CSR block, how often host traffic stalled the engine.

---
 rtl/npu_pkg.sv | 30 +++
 rtl/fram_port_arbiter_if.sv | 56 +++++
 rtl/fram_rr_arb2.sv | 51 +++++
 rtl/fram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_fram_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions used by the FRAM port arbiter.
//   DATA_WIDTH / FRAM_ADDR_WIDTH : FRAM word and word-address widths
//   fram_req_t                   : one FRAM access {en, we, addr, wdata}
//   fram_src_e                   : which requester owns the FRAM this cycle
//   rr_last_e                    : engine port served at the last engine grant
package npu_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int FRAM_ADDR_WIDTH = 14;

  typedef struct packed {
    logic                       en;
    logic                       we;
    logic [FRAM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      wdata;
  } fram_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HOST = 2'd1,
    SRC_RD   = 2'd2,
    SRC_WR   = 2'd3
  } fram_src_e;

  typedef enum logic {
    RR_LAST_RD = 1'b0,
    RR_LAST_WR = 1'b1
  } rr_last_e;

endpackage

// File: rtl/fram_port_arbiter_if.sv
// Bus bundle around the FRAM port arbiter: host BRAM-controller port,
// engine read port, engine write port and the FRAM macro port.
//   slave  : arbiter view (requests in, grants / FRAM controls out)
//   master : environment view (requesters and FRAM macro)
interface fram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);

  // Host port
  logic                  host_en;
  logic                  host_we;
  logic [ADDR_WIDTH+1:0] host_addr_byteidx;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  // Engine read port
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_rvalid;
  logic [DATA_WIDTH-1:0] rd_rdata;
  // Engine write port
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  // FRAM macro port
  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  host_en, host_we, host_addr_byteidx, host_wdata,
    output host_rdata,
    input  rd_req, rd_addr,
    output rd_gnt, rd_rvalid, rd_rdata,
    input  wr_req, wr_addr, wr_data,
    output wr_gnt,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output host_en, host_we, host_addr_byteidx, host_wdata,
    input  host_rdata,
    output rd_req, rd_addr,
    input  rd_gnt, rd_rvalid, rd_rdata,
    output wr_req, wr_addr, wr_data,
    input  wr_gnt,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/fram_rr_arb2.sv
// Two-way round-robin arbiter between the engine read and write ports.
//   clk, rst   : clock, synchronous active-high reset
//   inhibit_i  : blocks both grants (host owns the FRAM)
//   req_rd_i   : engine read request
//   req_wr_i   : engine write request
//   gnt_rd_o   : combinational read grant
//   gnt_wr_o   : combinational write grant
// On a tie the port not served at the last engine grant wins. The history
// resets to "write last" so the read port wins the first tie.
module fram_rr_arb2
  import npu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inhibit_i,
  input  logic req_rd_i,
  input  logic req_wr_i,
  output logic gnt_rd_o,
  output logic gnt_wr_o
);

  rr_last_e rr_last_q, rr_last_d;
  logic     blocked;

  // Grants are also suppressed while reset is asserted.
  assign blocked = inhibit_i | rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= RR_LAST_WR;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    gnt_rd_o  = 1'b0;
    gnt_wr_o  = 1'b0;
    rr_last_d = rr_last_q;
    if (!blocked) begin
      if (req_rd_i && (!req_wr_i || rr_last_q == RR_LAST_WR)) begin
        gnt_rd_o  = 1'b1;
        rr_last_d = RR_LAST_RD;
      end else if (req_wr_i) begin
        gnt_wr_o  = 1'b1;
        rr_last_d = RR_LAST_WR;
      end
    end
  end

endmodule

// File: rtl/fram_port_arbiter.sv
// Shares the single-port FRAM between the host BRAM-controller port
// (absolute priority, never stalled) and the conv engine's read and
// writeback ports (round-robin). Grants and FRAM controls are combinational
// in the request cycle; read data returns one cycle later.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : host / engine-rd / engine-wr / FRAM signals (slave modport)
//   coll_clr  : clears the collision counter (wins over increment)
//   coll_cnt  : saturating count of cycles where the host blocked an engine
module fram_port_arbiter
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = npu_pkg::FRAM_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fram_port_arbiter_if.slave   bus,
  input  logic                 coll_clr,
  output logic [CNT_WIDTH-1:0] coll_cnt
);

  logic           gnt_rd;
  logic           gnt_wr;
  fram_src_e      src;
  fram_req_t      req;
  logic [1:0]     tag_q, tag_d;      // {host_rd, eng_rd}
  logic [CNT_WIDTH-1:0] coll_q, coll_d;
  logic           unused_ok;

  fram_rr_arb2 u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .inhibit_i (bus.host_en),
    .req_rd_i  (bus.rd_req),
    .req_wr_i  (bus.wr_req),
    .gnt_rd_o  (gnt_rd),
    .gnt_wr_o  (gnt_wr)
  );

  // Source select: the host bypasses the arbiter entirely.
  always_comb begin
    src = SRC_NONE;
    if (bus.host_en) begin
      src = SRC_HOST;
    end else if (gnt_rd) begin
      src = SRC_RD;
    end else if (gnt_wr) begin
      src = SRC_WR;
    end
  end

  // FRAM request mux. When idle, address follows the read port and write
  // data follows the write port so the macro pins toggle only when those
  // ports change.
  always_comb begin
    req.en    = 1'b0;
    req.we    = 1'b0;
    req.addr  = bus.rd_addr;
    req.wdata = bus.wr_data;
    case (src)
      SRC_HOST: begin
        req.en    = 1'b1;
        req.we    = bus.host_we;
        req.addr  = bus.host_addr_byteidx[ADDR_WIDTH+1:2];
        req.wdata = bus.host_wdata;
      end
      SRC_RD: begin
        req.en = 1'b1;
      end
      SRC_WR: begin
        req.en   = 1'b1;
        req.we   = 1'b1;
        req.addr = bus.wr_addr;
      end
      default: ;
    endcase
  end

  assign bus.sram_en    = req.en;
  assign bus.sram_we    = req.we;
  assign bus.sram_addr  = req.addr;
  assign bus.sram_wdata = req.wdata;

  // Return-path tag, registered at the grant edge. The macro has one cycle
  // of read latency, so the tag lines up with sram_rdata the cycle after.
  assign tag_d = {bus.host_en & ~bus.host_we, gnt_rd};

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= 2'b00;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign bus.rd_rvalid  = tag_q[0];
  assign bus.rd_rdata   = bus.sram_rdata;
  assign bus.host_rdata = bus.sram_rdata;
  assign bus.rd_gnt     = gnt_rd;
  assign bus.wr_gnt     = gnt_wr;

  // Collision counter: clear wins, then saturating increment.
  always_comb begin
    coll_d = coll_q;
    if (coll_clr) begin
      coll_d = '0;
    end else if (bus.host_en && (bus.rd_req || bus.wr_req) && !(&coll_q)) begin
      coll_d = coll_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign coll_cnt = coll_q;

  // Byte-lane bits are ignored; the host read tag is kept for visibility
  // since host data is a plain pass-through of the macro output.
  assign unused_ok = ^{bus.host_addr_byteidx[1:0], tag_q[1]};

endmodule

// File: tb/tb_fram_port_arbiter.sv
// Self-checking bench for fram_port_arbiter. Includes a behavioural FRAM
// macro (read latency 1) and a reference memory updated from observed
// accesses; read expectations are queued at grant time and compared when
// the data returns.
module tb_fram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          coll_clr;
  logic [CW-1:0] coll_cnt;

  int checks   = 0;
  int failures = 0;

  fram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .coll_clr (coll_clr),
    .coll_cnt (coll_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FRAM macro model and reference memory
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'h5A000000 ^ (a * 32'h00010003);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
      else             bus.sram_rdata     <= mem[bus.sram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  logic [DW-1:0] rdq[$];
  logic [DW-1:0] hq[$];

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rdq.size() > 0) begin
      e = rdq.pop_front();
      check("rd_rvalid", {63'd0, bus.rd_rvalid}, 64'd1);
      check("rd_rdata", {32'd0, bus.rd_rdata}, {32'd0, e});
    end else begin
      check("rd_rvalid_idle", {63'd0, bus.rd_rvalid}, 64'd0);
    end
    if (hq.size() > 0) begin
      e = hq.pop_front();
      check("host_rdata", {32'd0, bus.host_rdata}, {32'd0, e});
    end
    if (bus.host_en)
      check("gnt_during_host", {62'd0, bus.rd_gnt, bus.wr_gnt}, 64'd0);
    if (bus.rd_gnt) rdq.push_back(ref_mem[bus.rd_addr]);
    if (bus.host_en && !bus.host_we) hq.push_back(ref_mem[bus.host_addr_byteidx[AW+1:2]]);
    if (bus.wr_gnt) ref_mem[bus.wr_addr] <= bus.wr_data;
    if (bus.host_en && bus.host_we) ref_mem[bus.host_addr_byteidx[AW+1:2]] <= bus.host_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic g_rd, g_wr;
    rst                   = 1'b1;
    coll_clr              = 1'b0;
    bus.host_en           = 1'b0;
    bus.host_we           = 1'b0;
    bus.host_addr_byteidx = '0;
    bus.host_wdata        = '0;
    bus.rd_req            = 1'b1;
    bus.rd_addr           = 14'd10;
    bus.wr_req            = 1'b1;
    bus.wr_addr           = 14'd100;
    bus.wr_data           = 32'hC0DE0000;

    // Reset with both engine requests pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_rd_gnt", {63'd0, bus.rd_gnt}, 64'd0);
      check("rst_wr_gnt", {63'd0, bus.wr_gnt}, 64'd0);
      check("rst_coll", {48'd0, coll_cnt}, 64'd0);
    end
    tick();
    rst = 1'b0;

    // Engine tie: alternation starting with read
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("tie_rd_gnt", {63'd0, bus.rd_gnt}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check("tie_wr_gnt", {63'd0, bus.wr_gnt}, (i % 2 == 1) ? 64'd1 : 64'd0);
      g_rd = bus.rd_gnt;
      g_wr = bus.wr_gnt;
      tick();
      if (g_rd) bus.rd_addr = bus.rd_addr + 1'b1;
      if (g_wr) begin
        bus.wr_addr = bus.wr_addr + 1'b1;
        bus.wr_data = bus.wr_data + 32'h11;
      end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;

    // Host-only write then read at byte address 0x10
    bus.host_en           = 1'b1;
    bus.host_we           = 1'b1;
    bus.host_addr_byteidx = 16'h0010;
    bus.host_wdata        = 32'hDEADBEEF;
    @(negedge clk);
    check("hw_sram_en", {63'd0, bus.sram_en}, 64'd1);
    check("hw_sram_we", {63'd0, bus.sram_we}, 64'd1);
    check("hw_sram_addr", {50'd0, bus.sram_addr}, 64'd4);
    check("hw_sram_wdata", {32'd0, bus.sram_wdata}, 64'hDEADBEEF);
    tick();
    bus.host_we = 1'b0;
    @(negedge clk);
    check("hr_sram_we", {63'd0, bus.sram_we}, 64'd0);
    check("hr_sram_addr", {50'd0, bus.sram_addr}, 64'd4);
    tick();
    bus.host_en = 1'b0;
    @(negedge clk);
    check("hr_data_direct", {32'd0, bus.host_rdata}, 64'hDEADBEEF);
    check("idle_sram_en", {63'd0, bus.sram_en}, 64'd0);
    check("idle_sram_we", {63'd0, bus.sram_we}, 64'd0);
    tick();

    // Host preemption of an engine read on the same word
    bus.host_en           = 1'b1;
    bus.host_we           = 1'b0;
    bus.host_addr_byteidx = 16'd80;
    bus.rd_req            = 1'b1;
    bus.rd_addr           = 14'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pre_rd_gnt", {63'd0, bus.rd_gnt}, 64'd0);
      tick();
    end
    bus.host_en = 1'b0;
    @(negedge clk);
    check("pre_release_gnt", {63'd0, bus.rd_gnt}, 64'd1);
    check("pre_coll", {48'd0, coll_cnt}, 64'd5);
    tick();
    bus.rd_req = 1'b0;

    // Engine write then read of word 200
    bus.wr_req  = 1'b1;
    bus.wr_addr = 14'd200;
    bus.wr_data = 32'h00000123;
    @(negedge clk);
    check("wr_gnt", {63'd0, bus.wr_gnt}, 64'd1);
    check("wr_sram_addr", {50'd0, bus.sram_addr}, 64'd200);
    check("wr_sram_we", {63'd0, bus.sram_we}, 64'd1);
    tick();
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 14'd200;
    @(negedge clk);
    check("wr_rd_gnt", {63'd0, bus.rd_gnt}, 64'd1);
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("wr_rd_rvalid", {63'd0, bus.rd_rvalid}, 64'd1);
    check("wr_rd_data", {32'd0, bus.rd_rdata}, 64'h00000123);
    tick();

    // Counter saturation, then clear during a collision
    bus.host_en           = 1'b1;
    bus.host_we           = 1'b1;
    bus.host_addr_byteidx = 16'd0;
    bus.host_wdata        = 32'hA5A5A5A5;
    bus.rd_req            = 1'b1;
    repeat (65540) tick();
    @(negedge clk);
    check("coll_sat", {48'd0, coll_cnt}, 64'hFFFF);
    tick();
    coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0;
    @(negedge clk);
    check("coll_clr", {48'd0, coll_cnt}, 64'd0);
    tick();
    bus.host_en = 1'b0;
    @(negedge clk);
    check("post_sat_rd_gnt", {63'd0, bus.rd_gnt}, 64'd1);
    tick();
    bus.rd_req = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
